// File: rtl/gnn_result_collector_if.sv
// gnn_result_collector_if: result-capture inputs and drain stream between the GNN harness (master) and the collector (slave)
interface gnn_result_collector_if #(
  parameter int DATA_W = 21
);
  logic                start;
  logic [8*DATA_W-1:0] res_data;
  logic [7:0]          res_ready;
  logic [DATA_W-1:0]   dout;
  logic [2:0]          dout_idx;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;
  logic [3:0]          dout_class;
  logic                busy;
  logic                timeout_err;
  logic                overrun_err;
  modport master (
    output start, res_data, res_ready, dout_ready,
    input  dout, dout_idx, dout_valid, dout_last, dout_class, busy, timeout_err, overrun_err
  );
  modport slave (
    input  start, res_data, res_ready, dout_ready,
    output dout, dout_idx, dout_valid, dout_last, dout_class, busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/gnn_result_collector.sv
// gnn_result_collector: captures each of eight GNN result words once per start, then drains them in slot order.
// Optional per-node class bits are built when GNN_COLLECT_CLASS_EN is defined.
module gnn_result_collector #(
  parameter int DATA_W         = 21,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 8
) (
  input logic                 clk,
  input logic                 rst,
  gnn_result_collector_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic              to_q, to_d, ov_q, ov_d, arm, fin;
  logic [DATA_W-1:0] word_q [8];
  logic [DATA_W-1:0] word_d [8];
  // a start on the final handshake re-arms straight into WAIT
  assign fin = state_q == DRAIN && bus.dout_ready && ptr_q == 3'd7;
  assign arm = bus.start && (state_q == IDLE || fin);
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    to_d    = to_q;
    ov_d    = ov_q;
    word_d  = word_q;
    if (state_q == WAIT) begin
      for (int k = 0; k < 8; k++)
        if (bus.res_ready[k] && !mask_q[k]) begin
          word_d[k] = bus.res_data[k*DATA_W +: DATA_W];
          mask_d[k] = 1'b1;
        end
      cnt_d = cnt_q + 1'b1;
      ptr_d = '0;
      if (mask_q == 8'hFF) state_d = DRAIN;
      else if (cnt_d == TO_W'(TIMEOUT_CYCLES) && mask_d != 8'hFF) begin
        to_d    = 1'b1;
        state_d = DRAIN;
      end
    end
    if (state_q == DRAIN && bus.dout_ready) begin
      state_d = fin ? IDLE : DRAIN;
      ptr_d   = ptr_q + 3'd1;
    end
    if (bus.start && state_q != IDLE && !fin) ov_d = 1'b1;
    if (arm) begin
      state_d = WAIT;
      mask_d  = '0;
      cnt_d   = '0;
      to_d    = 1'b0;
      ov_d    = 1'b0;
      word_d  = '{default: '0};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
      word_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
      word_q  <= word_d;
    end
  assign bus.dout_valid  = state_q == DRAIN;
  assign bus.busy        = state_q != IDLE;
  assign bus.dout        = bus.dout_valid ? word_q[ptr_q] : '0;
  assign bus.dout_idx    = bus.dout_valid ? ptr_q : 3'd0;
  assign bus.dout_last   = bus.dout_valid && ptr_q == 3'd7;
  assign bus.timeout_err = to_q;
  assign bus.overrun_err = ov_q;
`ifdef GNN_COLLECT_CLASS_EN
  logic [3:0] cls_q, cls_d;
  always_comb begin
    cls_d = cls_q;
    for (int n = 0; n < 4; n++)
      if (state_q != DRAIN) cls_d[n] = $signed(word_d[2*n+1]) > $signed(word_d[2*n]);
    if (state_d != DRAIN) cls_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cls_q <= '0;
    else cls_q <= cls_d;
  assign bus.dout_class = cls_q;
`else
  assign bus.dout_class = 4'b0000;
`endif
endmodule

// File: tb/tb_gnn_result_collector.sv
// tb_gnn_result_collector: table-driven and randomized transactions checked against a capture/drain reference model
module tb_gnn_result_collector;
  localparam int DW = 21;
  localparam int TO = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  gnn_result_collector_if #(.DATA_W(DW)) bus ();
  gnn_result_collector #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    int rt[8];
    int dmode;
    int rmode;
    int ov_at;
    bit rearm;
    bit armed;
    bit abort3;
    int exp_entry;
    bit exp_to;
  } vec_t;
  task automatic chk(input string n, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic zchk(input string s);
    chk({s, "_dout"}, longint'(bus.dout), 0);
    chk({s, "_idx"}, longint'(bus.dout_idx), 0);
    chk({s, "_valid"}, longint'(bus.dout_valid), 0);
    chk({s, "_last"}, longint'(bus.dout_last), 0);
    chk({s, "_class"}, longint'(bus.dout_class), 0);
    chk({s, "_busy"}, longint'(bus.busy), 0);
    chk({s, "_timeout"}, longint'(bus.timeout_err), 0);
    chk({s, "_overrun"}, longint'(bus.overrun_err), 0);
  endtask
  function automatic vec_t mk(input int rt[8], input int dm, input int rm, input int ov,
                              input bit re, input bit ar, input bit ab, input int ee, input bit et);
    vec_t v;
    v.rt = rt; v.dmode = dm; v.rmode = rm; v.ov_at = ov; v.rearm = re;
    v.armed = ar; v.abort3 = ab; v.exp_entry = ee; v.exp_to = et;
    return v;
  endfunction
  // drain begins one cycle after the last slot is captured, or at the timeout cycle if any slot is missing
  function automatic void model(input int rt[8], output int entry, output bit to);
    int mx = 0;
    bit never = 0;
    for (int k = 0; k < 8; k++)
      if (rt[k] == 0) never = 1;
      else if (rt[k] > mx) mx = rt[k];
    to = never || mx > TO;
    entry = to ? TO : mx + 1;
  endfunction
  task automatic run(input vec_t v);
    logic signed [DW-1:0] cap[8];
    logic [DW-1:0] x, pd;
    logic [8*DW-1:0] rd;
    logic [3:0] ecls;
    logic [2:0] pi;
    int d2[8] = '{5, 9, -3, -3, 7, -1, 0, 0};
    int got, n, i;
    bit stall, r;
    for (int k = 0; k < 8; k++) cap[k] = '0;
    if (!v.armed) begin
      bus.start = 1'b1;
      bus.res_ready = '0;
      step();
      bus.start = 1'b0;
      chk("arm_timeout", longint'(bus.timeout_err), 0);
      chk("arm_overrun", longint'(bus.overrun_err), 0);
      chk("arm_busy", longint'(bus.busy), 1);
    end
    got = -1;
    for (int c = 1; c <= 25; c++) begin
      for (int k = 0; k < 8; k++) begin
        x = DW'($urandom);
        if (v.rt[k] == 0 || c <= v.rt[k])
          x = v.dmode == 1 ? DW'(100*k - 350) : v.dmode == 2 ? DW'(d2[k]) : x;
        if (c == v.rt[k] && v.rt[k] <= TO) cap[k] = x;
        rd[k*DW +: DW] = x;
        bus.res_ready[k] = v.rt[k] != 0 && c >= v.rt[k];
      end
      bus.res_data = rd;
      bus.start = c == v.ov_at;
      step();
      bus.start = 1'b0;
      if (bus.dout_valid) begin
        got = c;
        break;
      end
    end
    chk("entry_cycle", got, v.exp_entry);
    chk("timeout_err", longint'(bus.timeout_err), longint'(v.exp_to));
    chk("overrun_err", longint'(bus.overrun_err), longint'(v.ov_at != 0));
    ecls = '0;
`ifdef GNN_COLLECT_CLASS_EN
    for (int m = 0; m < 4; m++) ecls[m] = cap[2*m+1] > cap[2*m];
`endif
    n = 0;
    i = 0;
    stall = 0;
    pd = '0;
    pi = '0;
    while (n < 8 && i < 100) begin
      chk("valid_hold", longint'(bus.dout_valid), 1);
      if (stall) begin
        chk("stall_dout", longint'(bus.dout), longint'(pd));
        chk("stall_idx", longint'(bus.dout_idx), longint'(pi));
      end
      if (v.abort3 && bus.dout_idx == 3'd3) begin
        bus.dout_ready = 1'b0;
        rst = 1'b1;
        #1;
        zchk("abort");
        step();
        rst = 1'b0;
        bus.res_ready = '0;
        return;
      end
      r = v.rmode == 0 ? 1'b1 : v.rmode == 1 ? (i % 3 == 0) : 1'($urandom_range(0, 1));
      bus.dout_ready = r;
      if (r) begin
        chk("idx", longint'(bus.dout_idx), n);
        chk("dout", longint'($signed(bus.dout)), longint'(cap[n]));
        chk("last", longint'(bus.dout_last), longint'(n == 7));
        chk("class", longint'(bus.dout_class), longint'(ecls));
        n++;
        if (n == 8 && v.rearm) bus.start = 1'b1;
      end
      stall = !r;
      pd = bus.dout;
      pi = bus.dout_idx;
      step();
      i++;
    end
    bus.dout_ready = 1'b0;
    bus.start = 1'b0;
    bus.res_ready = '0;
    chk("handshakes", n, 8);
    if (v.rmode == 0) chk("drain_cycles", i, 8);
    chk("valid_end", longint'(bus.dout_valid), 0);
    chk("busy_end", longint'(bus.busy), longint'(v.rearm));
    if (v.rearm) begin
      chk("rearm_timeout", longint'(bus.timeout_err), 0);
      chk("rearm_overrun", longint'(bus.overrun_err), 0);
    end
  endtask
  initial begin
    vec_t tbl[8];
    vec_t rv;
    bit pend;
    bus.start = 1'b0;
    bus.res_data = '0;
    bus.res_ready = '0;
    bus.dout_ready = 1'b0;
    #1;
    zchk("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    zchk("idle");
    tbl[0] = mk('{3, 3, 3, 3, 3, 3, 3, 3}, 1, 0, 0, 0, 0, 0, 4, 0);
    tbl[1] = mk('{8, 7, 6, 5, 4, 3, 2, 1}, 0, 0, 0, 0, 0, 0, 9, 0);
    tbl[2] = mk('{2, 2, 2, 2, 2, 2, 2, 2}, 0, 1, 0, 0, 0, 0, 3, 0);
    tbl[3] = mk('{1, 2, 3, 4, 5, 6, 0, 0}, 0, 0, 0, 0, 0, 0, 10, 1);
    tbl[4] = mk('{4, 4, 4, 4, 4, 4, 4, 4}, 0, 2, 2, 1, 0, 0, 5, 0);
    tbl[5] = mk('{10, 10, 10, 10, 10, 10, 10, 10}, 0, 0, 0, 0, 1, 0, 11, 0);
    tbl[6] = mk('{2, 2, 2, 2, 2, 2, 2, 2}, 2, 0, 0, 0, 0, 0, 3, 0);
    tbl[7] = mk('{1, 1, 1, 1, 1, 1, 1, 1}, 0, 0, 0, 0, 0, 1, 2, 0);
    for (int t = 0; t < 8; t++) run(tbl[t]);
    zchk("post_abort");
    pend = 0;
    for (int j = 0; j < 30; j++) begin
      for (int k = 0; k < 8; k++)
        rv.rt[k] = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 12));
      model(rv.rt, rv.exp_entry, rv.exp_to);
      rv.dmode = 0;
      rv.rmode = 2;
      rv.ov_at = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, rv.exp_entry)) : 0;
      rv.armed = pend;
      rv.rearm = j < 29 && $urandom_range(0, 3) == 0;
      rv.abort3 = 0;
      pend = rv.rearm;
      run(rv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/gnn_result_collector.md
Name: gnn_result_collector

Overview:
- Receiving end of the GNN result interface. Sits downstream of the 4-node GNN top.
- Observes the eight per-node result words and their level ready flags after a start pulse, and captures each word once.
- When all eight words are captured, streams them out in fixed order over a valid/ready handshake to the host or test harness.
- Also reports timeout and overrun conditions.

Parameters:
- DATA_W, 21: width of each signed result word; must match GNN output width.
- TIMEOUT_CYCLES, 64: cycles in WAIT without full capture before abort; must be ≥1.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse issued alongside the GNN in_ready; arms a capture.
- res_data  in  8*DATA_W  packed signed results; slot k=2*node+out (k0=out0_node0 … k7=out1_node3).
- res_ready  in  8  level ready flag per slot, same indexing as res_data.
- dout  out  DATA_W  current output word (signed).
- dout_idx  out  3  slot index of dout.
- dout_valid  out  1  word available.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  high with slot 7.
- dout_class  out  4  per-node class bits; see Optional Feature.
- busy  out  1  high in WAIT or DRAIN.
- timeout_err  out  1  sticky until next accepted start.
- overrun_err  out  1  sticky until next accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: dout, dout_idx, dout_valid, dout_last, dout_class, busy, timeout_err, overrun_err.
  - Capture mask, timeout counter and buffer all cleared.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - start=1 → WAIT next cycle.
  - On that transition: mask=0, timeout counter=0, both error flags cleared.
- WAIT:
  - Each cycle, for every k with res_ready[k]=1 and mask[k]=0: buf[k]<=res_data[k], mask[k]<=1.
  - Several slots may capture in the same cycle.
  - Once captured, a slot is never overwritten, even if res_ready drops and rises again.
  - Flags sampled on the start cycle itself are ignored; capture begins the cycle after start.
  - mask reaches 8'hFF → DRAIN on the next cycle. Latency from the last flag high to dout_valid is 2 clocks.
  - Counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES with mask≠FF: timeout_err<=1, then DRAIN.
  - On timeout, uncaptured slots drain as 0.
- DRAIN:
  - dout_valid=1, dout=buf[ptr], dout_idx=ptr, dout_last=(ptr==7).
  - ptr starts at 0 on DRAIN entry.
  - dout and dout_idx stay stable while dout_valid=1 and dout_ready=0 (AXI-stream rules; valid never drops without a handshake).
  - Handshake (valid&ready) on ptr<7 → ptr+1. On ptr==7 → IDLE, dout_valid=0 next cycle.
  - Maximum throughput: 1 word per clock; 8 words take 8 cycles with dout_ready held high.
- busy = (state≠IDLE), registered.
- start while busy:
  - Ignored, overrun_err<=1.
  - Exception: start coincident with the final handshake (ptr==7 accepted) is accepted. Go directly to WAIT, clear flags and mask; overrun_err is not set.
- Reset mid-WAIT or mid-DRAIN: immediate return to IDLE; partial data is discarded and no dout_last is produced.
- Arithmetic: none on data path; words are passed bit-exact, sign preserved.

Optional Feature:
- Macro GNN_COLLECT_CLASS_EN.
- Defined:
  - On DRAIN entry, dout_class[n] <= ($signed(buf[2n+1]) > $signed(buf[2n])) for n=0..3.
  - Ties give 0.
  - Held stable through DRAIN and cleared on return to IDLE or reset.
  - Adds one signed DATA_W comparator per node.
- Not defined: dout_class tied to 4'b0000 and no comparators are synthesised. All other behaviour is identical.

Test Plan:
- Reset, then start. Slot k is given value 100·k−350 and all res_ready rise together 3 cycles later, with dout_ready=1. Required:
  - dout_valid rises 2 cycles after the flags.
  - Words −350, −250, −150, −50, 50, 150, 250, 350 appear on idx 0..7 in 8 consecutive cycles.
  - dout_last only on idx7; busy falls after.
- Flags rise staggered one slot per cycle (k7 first), and res_data changes after each capture. Required: the first-captured values are output, never the later ones.
- dout_ready toggles 1,0,0,1… during DRAIN. Required: dout and dout_idx stay stable across stalls, with exactly 8 handshakes.
- TIMEOUT_CYCLES=10, only slots 0–5 ever ready. Required:
  - timeout_err=1 at WAIT cycle 10.
  - Drain gives 6 captured words, then 0, 0.
  - timeout_err clears on the next start.
- A start pulse during WAIT sets overrun_err=1 and the capture continues unaffected. A start on the idx7 handshake cycle re-arms with no overrun.
- With GNN_COLLECT_CLASS_EN, node0 (out0=5, out1=9) and node1 (out0=−3, out1=−3). Required: dout_class[1:0]=2'b01. Without the macro, dout_class=0. Also assert rst mid-DRAIN at idx3: all outputs return to 0 immediately.
